// File: rtl/posit_acc_encode.sv
// posit_acc_encode: converts a segmented fixed-point accumulator into a
// rounded posit word over a scan / normalise / round / output sequence.
module posit_acc_encode #(
   parameter int WIDTH    = 8,
   parameter int EXP      = 2,
   parameter int K        = 9,
   parameter int ACC      = (2**EXP)*(WIDTH-2),
   parameter int ACC_HEAD = $clog2(K)+2
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                acc_rdy,
   input  logic [ACC_HEAD-1:0] acc_head,
   input  logic [ACC-1:0]      acc_seg0,
   input  logic [ACC-1:0]      acc_seg1,
   input  logic [ACC-1:0]      acc_seg2,
   input  logic [ACC-1:0]      acc_seg3,
   input  logic                acc_sign,
   input  logic                out_rdy,
   output logic                out_vld,
   output logic [WIDTH-1:0]    out_posit,
   output logic                busy_o,
   output logic                ovr_o
);

   localparam int MW   = ACC_HEAD + 4*ACC;
   localparam int BP   = 2*ACC;
   localparam int PW   = $clog2(MW) + 1;
   localparam int SW   = PW + 1;
   localparam int SGW  = (ACC > ACC_HEAD) ? ACC : ACC_HEAD;
   localparam int SMAX = (2**EXP)*(WIDTH-2);
   localparam int XW   = WIDTH + EXP + MW;

   localparam logic signed [SW-1:0] BP_S   = SW'(BP);
   localparam logic signed [SW-1:0] SMAX_S = SW'(SMAX);
   localparam logic signed [SW-1:0] SMIN_S = SW'(-SMAX);

   localparam logic [ACC_HEAD-1:0] HEAD_MASK =
      {1'b0, {(ACC_HEAD-1){1'b1}}};
   localparam logic [WIDTH-1:0] MAXP = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] MINP = WIDTH'(1);
   localparam logic [WIDTH-1:0] ONES = '1;
   localparam logic [WIDTH-1:0] TOP  = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE,
      S_SCAN,
      S_NORM,
      S_RND,
      S_OUT
   } state_t;

   state_t                 state_q, state_d;
   logic                   rdy_q, rdy_d;
   logic [ACC_HEAD-1:0]    head_q, head_d;
   logic [ACC-1:0]         s0_q, s0_d;
   logic [ACC-1:0]         s1_q, s1_d;
   logic [ACC-1:0]         s2_q, s2_d;
   logic [ACC-1:0]         s3_q, s3_d;
   logic                   sign_q, sign_d;
   logic [2:0]             idx_q, idx_d;
   logic [PW-1:0]          p_q, p_d;
   logic                   zero_q, zero_d;
   logic signed [SW-1:0]   k_q, k_d;
   logic [EXP-1:0]         e_q, e_d;
   logic [MW-1:0]          frac_q, frac_d;
   logic                   hi_q, hi_d;
   logic                   lo_q, lo_d;
   logic                   vld_q, vld_d;
   logic [WIDTH-1:0]       pos_q, pos_d;
   logic                   ovr_q, ovr_d;

   logic                   start;
   logic [SGW-1:0]         seg_cur;
   logic [PW-1:0]          seg_base;
   logic [PW-1:0]          seg_pos;
   logic                   seg_nz;
   logic [MW-1:0]          m_all;
   logic signed [SW-1:0]   scale;
   logic [PW-1:0]          sh;
   logic [SW-1:0]          nk;
   logic [SW-1:0]          kp1;
   logic [SW-1:0]          rsh;
   logic [WIDTH-1:0]       reg_w;
   logic [XW-1:0]          xs;
   logic [WIDTH-2:0]       body;
   logic                   guard;
   logic                   sticky;
   logic [WIDTH-1:0]       rnd;
   logic [WIDTH-1:0]       mag;
   logic [WIDTH-1:0]       res;

   assign start = acc_rdy & ~rdy_q;
   assign m_all = {head_q, s0_q, s1_q, s2_q, s3_q};

   // Pick the segment under scan and locate its highest set bit.
   always_comb begin
      seg_cur  = '0;
      seg_base = '0;
      unique case (idx_q)
         3'd0: begin
            seg_cur  = SGW'(head_q);
            seg_base = PW'(4*ACC);
         end
         3'd1: begin
            seg_cur  = SGW'(s0_q);
            seg_base = PW'(3*ACC);
         end
         3'd2: begin
            seg_cur  = SGW'(s1_q);
            seg_base = PW'(2*ACC);
         end
         3'd3: begin
            seg_cur  = SGW'(s2_q);
            seg_base = PW'(ACC);
         end
         3'd4: begin
            seg_cur  = SGW'(s3_q);
            seg_base = '0;
         end
         default: begin
            seg_cur  = '0;
            seg_base = '0;
         end
      endcase
      seg_nz  = |seg_cur;
      seg_pos = '0;
      for (int j = 0; j < SGW; j++) begin
         if (seg_cur[j]) seg_pos = PW'(j);
      end
   end

   // Binary scale of the leading one and the left-justifying shift.
   always_comb begin
      scale = $signed({1'b0, p_q}) - BP_S;
      sh    = PW'(MW) - p_q;
   end

   // Regime/exponent/fraction string, then round-to-nearest-even.
   always_comb begin
      nk    = -k_q;
      kp1   = k_q + SW'(1);
      reg_w = '0;
      rsh   = '0;
      if (k_q[SW-1]) begin
         reg_w = TOP >> nk;
         rsh   = SW'(WIDTH-1) - nk;
      end else begin
         reg_w = ~(ONES >> kp1);
         rsh   = SW'(WIDTH-2) - k_q;
      end
      xs = {reg_w, {(EXP+MW){1'b0}}}
         | (XW'({e_q, frac_q}) << rsh);
      body   = xs[XW-1 -: WIDTH-1];
      guard  = xs[XW-WIDTH];
      sticky = |xs[XW-WIDTH-1:0];
      rnd    = {1'b0, body}
             + {{(WIDTH-1){1'b0}}, guard & (body[0] | sticky)};
      mag = rnd;
      if (rnd[WIDTH-1])  mag = MAXP;
      if (rnd == '0)     mag = MINP;
      if (hi_q)          mag = MAXP;
      if (lo_q)          mag = MINP;
      res = sign_q ? (~mag + WIDTH'(1)) : mag;
      if (zero_q) res = '0;
   end

   // Sequencer: next-state and all register updates.
   always_comb begin
      state_d = state_q;
      rdy_d   = acc_rdy;
      head_d  = head_q;
      s0_d    = s0_q;
      s1_d    = s1_q;
      s2_d    = s2_q;
      s3_d    = s3_q;
      sign_d  = sign_q;
      idx_d   = idx_q;
      p_d     = p_q;
      zero_d  = zero_q;
      k_d     = k_q;
      e_d     = e_q;
      frac_d  = frac_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      vld_d   = vld_q;
      pos_d   = pos_q;
      ovr_d   = ovr_q | (start && (state_q != S_IDLE));
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               head_d  = acc_head & HEAD_MASK;
               s0_d    = acc_seg0;
               s1_d    = acc_seg1;
               s2_d    = acc_seg2;
               s3_d    = acc_seg3;
               sign_d  = acc_sign;
               idx_d   = '0;
               p_d     = '0;
               zero_d  = 1'b0;
               state_d = S_SCAN;
            end
         end
         S_SCAN: begin
            if (seg_nz) begin
               p_d     = seg_base + seg_pos;
               state_d = S_NORM;
            end else if (idx_q == 3'd4) begin
               zero_d  = 1'b1;
               state_d = S_NORM;
            end else begin
               idx_d = idx_q + 3'd1;
            end
         end
         S_NORM: begin
            k_d     = scale >>> EXP;
            e_d     = scale[EXP-1:0];
            frac_d  = m_all << sh;
            hi_d    = scale > SMAX_S;
            lo_d    = scale < SMIN_S;
            state_d = S_RND;
         end
         S_RND: begin
            pos_d   = res;
            vld_d   = 1'b1;
            state_d = S_OUT;
         end
         S_OUT: begin
            if (out_rdy) begin
               vld_d   = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         rdy_q   <= 1'b1;
         head_q  <= '0;
         s0_q    <= '0;
         s1_q    <= '0;
         s2_q    <= '0;
         s3_q    <= '0;
         sign_q  <= 1'b0;
         idx_q   <= '0;
         p_q     <= '0;
         zero_q  <= 1'b0;
         k_q     <= '0;
         e_q     <= '0;
         frac_q  <= '0;
         hi_q    <= 1'b0;
         lo_q    <= 1'b0;
         vld_q   <= 1'b0;
         pos_q   <= '0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rdy_q   <= rdy_d;
         head_q  <= head_d;
         s0_q    <= s0_d;
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         s3_q    <= s3_d;
         sign_q  <= sign_d;
         idx_q   <= idx_d;
         p_q     <= p_d;
         zero_q  <= zero_d;
         k_q     <= k_d;
         e_q     <= e_d;
         frac_q  <= frac_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         vld_q   <= vld_d;
         pos_q   <= pos_d;
         ovr_q   <= ovr_d;
      end
   end

   assign out_vld   = vld_q;
   assign out_posit = pos_q;
   assign busy_o    = (state_q != S_IDLE);
   assign ovr_o     = ovr_q;

endmodule

// File: tb/tb_posit_acc_encode.sv
// tb_posit_acc_encode: random and directed stimulus against a posit
// reference built from decoded posit values and bit-string midpoints.
module tb_posit_acc_encode;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        acc_rdy;
   logic [5:0]  acc_head;
   logic [23:0] acc_seg0;
   logic [23:0] acc_seg1;
   logic [23:0] acc_seg2;
   logic [23:0] acc_seg3;
   logic        acc_sign;
   logic        out_rdy;
   logic        out_vld;
   logic [7:0]  out_posit;
   logic        busy_o;
   logic        ovr_o;

   int n_chk = 0;
   int n_err = 0;

   logic [127:0] v8 [128];
   logic [127:0] one = 128'd1;

   posit_acc_encode dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .acc_rdy   (acc_rdy),
      .acc_head  (acc_head),
      .acc_seg0  (acc_seg0),
      .acc_seg1  (acc_seg1),
      .acc_seg2  (acc_seg2),
      .acc_seg3  (acc_seg3),
      .acc_sign  (acc_sign),
      .out_rdy   (out_rdy),
      .out_vld   (out_vld),
      .out_posit (out_posit),
      .busy_o    (busy_o),
      .ovr_o     (ovr_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Value of an n-bit posit (es=2) scaled by 2**48.
   function automatic logic [127:0] pdec(input logic [15:0] pat,
                                          input int n);
      int i, run, k, e, fb, sc;
      logic r;
      logic [127:0] f;
      i = n - 2;
      r = pat[i];
      run = 0;
      while (i >= 0 && pat[i] == r) begin
         run++;
         i--;
      end
      k = r ? run - 1 : -run;
      i--;
      e = 0;
      for (int b = 0; b < 2; b++) begin
         e = e * 2 + ((i >= 0) ? int'(pat[i]) : 0);
         i--;
      end
      fb = (i >= 0) ? i + 1 : 0;
      f = 128'(pat) & ((one << fb) - 1);
      sc = 4 * k + e;
      return ((one << fb) | f) << (sc + 48 - fb);
   endfunction

   function automatic logic [7:0] ref_posit(input logic [127:0] m,
                                             input logic sgn);
      int c;
      logic [127:0] mid;
      logic [7:0] mag;
      if (m == 0) return 8'h00;
      c = 0;
      for (int j = 1; j < 128; j++) if (v8[j] <= m) c = j;
      if (c > 0 && c < 127) begin
         mid = pdec(16'((c << 1) | 1), 9);
         if (m > mid || (m == mid && (c % 2) == 1)) c++;
      end
      if (c == 0) c = 1;
      mag = 8'(c);
      return sgn ? -mag : mag;
   endfunction

   function automatic int lat_of(input logic [127:0] m);
      if (m[100:96] != 0) return 4;
      if (m[95:72] != 0)  return 5;
      if (m[71:48] != 0)  return 6;
      if (m[47:24] != 0)  return 7;
      return 8;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic drive_m(input logic [127:0] m, input logic sgn);
      acc_head    = m[101:96];
      acc_head[5] = 1'($urandom);
      acc_seg0    = m[95:72];
      acc_seg1    = m[71:48];
      acc_seg2    = m[47:24];
      acc_seg3    = m[23:0];
      acc_sign    = sgn;
   endtask

   task automatic txn(input logic [127:0] m, input logic sgn,
                      input logic [7:0] expv, input int stall,
                      input bit pulse);
      int cyc;
      bit got;
      drive_m(m, sgn);
      acc_rdy = 1'b1;
      out_rdy = 1'b0;
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < 40) begin
         @(posedge clk_i); #1;
         cyc++;
         if (cyc == 1) drive_m(rnd128(), ~sgn);
         if (cyc == 2) acc_rdy = 1'b0;
         if (out_vld) got = 1'b1;
      end
      if (!got) begin
         chk("vld_timeout", 32'(cyc), 32'(lat_of(m)));
         return;
      end
      chk("latency", 32'(cyc), 32'(lat_of(m)));
      chk("posit", 32'(out_posit), 32'(expv));
      chk("busy_out", 32'(busy_o), 32'd1);
      for (int s = 0; s < stall; s++) begin
         if (pulse && s == 0) acc_rdy = 1'b1;
         if (pulse && s == 1) acc_rdy = 1'b0;
         @(posedge clk_i); #1;
         chk("hold_vld", 32'(out_vld), 32'd1);
         chk("hold_posit", 32'(out_posit), 32'(expv));
      end
      acc_rdy = 1'b0;
      out_rdy = 1'b1;
      @(posedge clk_i); #1;
      out_rdy = 1'b0;
      chk("vld_drop", 32'(out_vld), 32'd0);
      chk("idle_busy", 32'(busy_o), 32'd0);
   endtask

   logic [127:0] m;
   logic         sgn;
   int           mode, c, p, seen;

   initial begin
      for (int j = 0; j < 128; j++) v8[j] = pdec(16'(j), 8);
      rst_i   = 1'b1;
      acc_rdy = 1'b0;
      out_rdy = 1'b0;
      drive_m(128'd0, 1'b0);
      repeat (3) @(posedge clk_i);
      #1;
      chk("rst_vld", 32'(out_vld), 32'd0);
      chk("rst_posit", 32'(out_posit), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_ovr", 32'(ovr_o), 32'd0);
      rst_i = 1'b0;
      @(posedge clk_i); #1;

      txn(one << 48, 1'b0, 8'h40, 0, 1'b0);
      txn((one << 48) | (one << 47), 1'b1, 8'hBC, 1, 1'b0);
      txn(one << 78, 1'b0, 8'h7F, 0, 1'b0);
      txn(one << 0, 1'b0, 8'h01, 0, 1'b0);
      txn(128'd0, 1'b1, 8'h00, 0, 1'b0);
      chk("ovr_clean", 32'(ovr_o), 32'd0);

      txn(one << 48, 1'b0, 8'h40, 3, 1'b1);
      chk("ovr_set", 32'(ovr_o), 32'd1);
      repeat (2) @(posedge clk_i);
      #1;
      chk("no_second", 32'(out_vld | busy_o), 32'd0);

      drive_m(one << 48, 1'b0);
      acc_rdy = 1'b1;
      @(posedge clk_i); #1;
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      chk("mid_rst_busy", 32'(busy_o), 32'd0);
      chk("mid_rst_vld", 32'(out_vld), 32'd0);
      chk("mid_rst_posit", 32'(out_posit), 32'd0);
      chk("mid_rst_ovr", 32'(ovr_o), 32'd0);
      seen = 0;
      repeat (12) begin
         @(posedge clk_i); #1;
         if (out_vld || busy_o) seen++;
      end
      chk("held_rdy_ignored", 32'(seen), 32'd0);
      acc_rdy = 1'b0;
      @(posedge clk_i); #1;
      txn(one << 47, 1'b0, ref_posit(one << 47, 1'b0), 0, 1'b0);

      for (int t = 0; t < 80; t++) begin
         mode = int'($urandom_range(0, 4));
         sgn  = 1'($urandom);
         case (mode)
            0: m = 128'd0;
            1: begin
               c = int'($urandom_range(1, 125));
               m = pdec(16'((c << 1) | 1), 9);
            end
            2: m = one << $urandom_range(0, 100);
            3: begin
               p = int'($urandom_range(0, 100));
               m = (rnd128() & ((one << p) - 1)) | (one << p);
            end
            default: begin
               p = 48 + int'($urandom_range(0, 52)) - 26;
               m = (rnd128() & ((one << p) - 1)) | (one << p);
            end
         endcase
         txn(m, sgn, ref_posit(m, sgn),
             int'($urandom_range(0, 2)), 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
